counter_4bit: RTL and testbench
===============================

// Module: counter_4bit
// PURPOSE
//  Free-running binary up-counter with asynchronous active-low reset.
//  Default build is a 4-bit modulo-16 counter; the modulus is parameterised.
//  Provides a combinational terminal-count flag and a registered wrap pulse.
//  Used as a basic timebase/sequencer and as a sequential-logic reference block.
// PARAMETERS
//  WIDTH    4   counter width in bits (>=1)
//  MAX_VAL  15  terminal value; count wraps MAX_VAL->0 (must be <= 2**WIDTH-1)
// PORTS
//  clk    in   1      clock; all state updates on rising edge
//  rstn   in   1      async active-low reset
//  out    out  WIDTH  current count (registered)
//  tc     out  1      terminal count: 1 when out==MAX_VAL (combinational from out)
//  wrap   out  1      registered 1-cycle pulse, high in the cycle after out wraps to 0
//  gray   out  WIDTH  Gray-coded count; present only when COUNTER_4BIT_GRAY_EN is defined
// BEHAVIOUR
//  - One clock (clk); reset is asynchronous and active-low (rstn).
//  - rstn=0: out=0, wrap=0, gray=0 immediately, independent of clk; tc=(MAX_VAL==0).
//  - rstn=1: on each rising clk edge, out<=out+1 if out<MAX_VAL, else out<=0.
//  - No enable/load inputs: the counter advances on every edge while out of reset.
//  - First increment is at the first rising edge with rstn already high.
//    rstn released between edges: counting starts at the next edge.
//  - Latency: out reflects an edge immediately after that edge (1-cycle register).
//  - wrap<=1 on the edge where out goes MAX_VAL->0, else wrap<=0; never set by reset.
//  - Reset mid-count: out forces to 0 asynchronously; count restarts from 0.
//  - Values above MAX_VAL are unreachable; if forced, the next edge loads 0.
//  - Arithmetic is unsigned, WIDTH bits, no carry output.
// CONFIGURATION
//  COUNTER_4BIT_GRAY_EN defined: adds output port gray, registered, with
//    gray==next_out^(next_out>>1), updated on the same edge as out and reset to 0.
//    Gray sequence is exact only when MAX_VAL==2**WIDTH-1.
//  Not defined: no gray port and no gray logic; all other behaviour is identical.
// TESTING
//  T1 reset: rstn=0 from t=0, clk period 10 -> out=0, wrap=0 across all edges.
//  T2 count: rstn 0->1 at t=20 (edges at 5,15,25,...) -> out=1 after the t=25 edge,
//     and out=8 just before t=100.
//  T3 async reset mid-count: rstn=0 at t=100 (between edges) -> out=0 at t=100,
//     not at the next edge; holds 0 until t=150.
//  T4 restart: rstn=1 at t=150 -> out=1 after t=155, out=2 after t=165.
//  T5 wrap: run >=17 edges -> out 15->0, tc=1 only while out==15,
//     wrap=1 exactly one cycle after the wrap.
//  T6 GRAY_EN build: count 0..15 -> gray = 0,1,3,2,6,7,5,4,12,...,8,
//     with exactly one bit changing per edge, including 8->0 at the wrap.

Source files
------------

// File: rtl/counter_4bit.sv
// counter_4bit: free-running modulo-(MAX_VAL+1) up-counter with terminal-count flag and wrap pulse.
// Define COUNTER_4BIT_GRAY_EN to add a registered Gray-coded copy of the count on port gray.
module counter_4bit #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
`ifdef COUNTER_4BIT_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    logic [WIDTH-1:0] next_out;
    // Anything at or above MAX (including forced out-of-range values) reloads 0.
    assign next_out = (out < MAX) ? out + WIDTH'(1) : '0;
    assign tc = out == MAX;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            out  <= next_out;
            wrap <= tc;
        end
    end
`ifdef COUNTER_4BIT_GRAY_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) gray <= '0;
        else gray <= next_out ^ (next_out >> 1);
    end
`endif
endmodule

// File: tb/tb_counter_4bit.sv
// tb_counter_4bit: directed checks of counter_4bit (default 4-bit/15 and a MAX_VAL=9 instance).
module tb_counter_4bit;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] out, out9;
    logic       tc, wrap, tc9, wrap9;
`ifdef COUNTER_4BIT_GRAY_EN
    logic [3:0] gray, gray9;
    logic [3:0] pg;
`endif
    int checks = 0;
    int errors = 0;
    logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                              4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
    logic [3:0] m, m9;
    logic       wr, wr9, found;

    counter_4bit dut (
        .clk(clk), .rstn(rstn), .out(out), .tc(tc), .wrap(wrap)
`ifdef COUNTER_4BIT_GRAY_EN
        , .gray(gray)
`endif
    );

    counter_4bit #(.WIDTH(4), .MAX_VAL(9)) dut9 (
        .clk(clk), .rstn(rstn), .out(out9), .tc(tc9), .wrap(wrap9)
`ifdef COUNTER_4BIT_GRAY_EN
        , .gray(gray9)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial begin
        #10;
        check("rst_out_t10", out, 0);
        check("rst_wrap_t10", wrap, 0);
        check("rst_tc_t10", tc, 0);
        check("rst_out9_t10", out9, 0);
        #10;
        check("rst_out_t20", out, 0);
        check("rst_wrap_t20", wrap, 0);
        rstn = 1'b1;
        #10;
        check("first_inc", out, 1);
        #68;
        check("out_t98", out, 8);
        check("out9_t98", out9, 8);
        #2 rstn = 1'b0;
        #1;
        check("async_out", out, 0);
        check("async_out9", out9, 0);
        #39;
        check("hold_out_t140", out, 0);
        check("hold_wrap_t140", wrap, 0);
        #10 rstn = 1'b1;
        #10;
        check("restart_1", out, 1);
        #10;
        check("restart_2", out, 2);
        m = 4'd2;
        m9 = 4'd2;
`ifdef COUNTER_4BIT_GRAY_EN
        check("gray_2", gray, gtab[2]);
        pg = gtab[2];
`endif
        for (int i = 0; i < 40; i++) begin
            #10;
            wr  = (m == 4'd15);
            wr9 = (m9 == 4'd9);
            m   = wr ? 4'd0 : m + 4'd1;
            m9  = wr9 ? 4'd0 : m9 + 4'd1;
            check("run_out", out, m);
            check("run_tc", tc, m == 4'd15);
            check("run_wrap", wrap, wr);
            check("run_out9", out9, m9);
            check("run_tc9", tc9, m9 == 4'd9);
            check("run_wrap9", wrap9, wr9);
`ifdef COUNTER_4BIT_GRAY_EN
            check("run_gray", gray, gtab[m]);
            check("gray_onebit", $countones(gray ^ pg), 1);
            pg = gray;
`endif
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #10;
            found = wrap;
        end
        check("wrap_seen", found, 1);
        #1 rstn = 1'b0;
        #1;
        check("rst_clears_wrap", wrap, 0);
        check("rst_clears_out", out, 0);
`ifdef COUNTER_4BIT_GRAY_EN
        check("rst_clears_gray", gray, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
